// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter sequencer.
// Contents:
//   state_t          sequencer states (IDLE, CLEAR, RUN, SETTLE, RESP)
//   CNT_BIN/CNT_BCD  counter type encodings driven on ctr_type
//   CNT_UP/CNT_DOWN  counter direction encodings driven on ctr_mode
//   INIT_*           value the counter takes when cleared
//   BCD_MOD          modulus of the BCD counter
package cnt_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic CNT_BIN  = 1'b0;
    localparam logic CNT_BCD  = 1'b1;
    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    localparam logic [3:0] INIT_UP       = 4'd0;
    localparam logic [3:0] INIT_BIN_DOWN = 4'd15;
    localparam logic [3:0] INIT_BCD_DOWN = 4'd9;

    localparam int BCD_MOD = 10;

endpackage

// File: rtl/cnt_seq_model.sv
// Expected-value model: the count the 4-bit counter should show after being
// cleared and then enabled for 'count' clocks.
// Ports:
//   cnt_type  in  1      0 = binary, 1 = BCD
//   cnt_mode  in  1      0 = up, 1 = down
//   count     in  LEN_W  number of counting clocks
//   expected  out 4      predicted counter value
// Purely combinational; only instantiated when CNT_SEQ_CHECK_EN is defined.
module cnt_seq_model
    import cnt_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             cnt_type,
    input  logic             cnt_mode,
    input  logic [LEN_W-1:0] count,
    output logic [3:0]       expected
);

    logic [3:0] bcd_rem;

    always_comb begin
        bcd_rem  = 4'(count % LEN_W'(BCD_MOD));
        expected = INIT_UP + count[3:0];
        if (cnt_type == CNT_BIN) begin
            // Binary wraps naturally in 4 bits, so only the low nibble matters.
            if (cnt_mode == CNT_DOWN) begin
                expected = INIT_BIN_DOWN - count[3:0];
            end
        end else begin
            if (cnt_mode == CNT_UP) begin
                expected = INIT_UP + bcd_rem;
            end else begin
                // bcd_rem is 0..9, so 9 - bcd_rem never underflows.
                expected = INIT_BCD_DOWN - bcd_rem;
            end
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command-driven sequencer for the 4-bit up/down binary/BCD counter.
// Accepts a run command, clears the counter on a gated edge, enables it for
// exactly cmd_len clocks (or until cmd_abort), captures the final count and
// returns it over a valid/ready response channel.
// Ports:
//   clk, mstr_reset_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready               command handshake (ready = IDLE)
//   cmd_type/cmd_mode/cmd_len         counter type, direction, tick count
//   cmd_abort                         early stop, honoured in RUN only
//   ctr_en/ctr_type/ctr_mode/ctr_reset counter control pins (registered)
//   ctr_out                           counter value
//   rsp_valid/rsp_ready               response handshake
//   rsp_value/rsp_count/rsp_aborted/rsp_err  response fields
// Build option: define CNT_SEQ_CHECK_EN to compare the captured value against
// an expected-value model and report it on rsp_err; otherwise rsp_err is 0.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             mstr_reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_type,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_abort,
    output logic             ctr_en,
    output logic             ctr_type,
    output logic             ctr_mode,
    output logic             ctr_reset,
    input  logic [3:0]       ctr_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_value,
    output logic [LEN_W-1:0] rsp_count,
    output logic             rsp_aborted,
    output logic             rsp_err
);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             aborted_reg, aborted_next;
    logic             accept;

    logic             ctr_en_reg, ctr_reset_reg, ctr_type_reg, ctr_mode_reg;
    logic             rsp_valid_reg, rsp_aborted_reg;
    logic [3:0]       rsp_value_reg;
    logic [LEN_W-1:0] rsp_count_reg;

    assign cmd_ready = (state_reg == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        aborted_next = aborted_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next   = S_CLEAR;
                    cnt_next     = '0;
                    aborted_next = 1'b0;
                end
            end
            S_CLEAR: begin
                state_next = (len_reg != '0) ? S_RUN : S_SETTLE;
            end
            S_RUN: begin
                // Every RUN cycle is an enabled edge, including an aborted one.
                cnt_next = cnt_reg + LEN_W'(1);
                if (cmd_abort) begin
                    state_next   = S_SETTLE;
                    aborted_next = 1'b1;
                end else if (cnt_next == len_reg) begin
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control and response outputs are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!mstr_reset_n) begin
            state_reg       <= S_IDLE;
            len_reg         <= '0;
            cnt_reg         <= '0;
            aborted_reg     <= 1'b0;
            ctr_en_reg      <= 1'b0;
            ctr_reset_reg   <= 1'b0;
            ctr_type_reg    <= 1'b0;
            ctr_mode_reg    <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_value_reg   <= '0;
            rsp_count_reg   <= '0;
            rsp_aborted_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            aborted_reg   <= aborted_next;
            ctr_en_reg    <= (state_next == S_CLEAR) || (state_next == S_RUN);
            ctr_reset_reg <= (state_next == S_CLEAR);
            rsp_valid_reg <= (state_next == S_RESP);
            if (accept) begin
                len_reg      <= cmd_len;
                ctr_type_reg <= cmd_type;
                ctr_mode_reg <= cmd_mode;
            end
            // Counter has been gated off for the whole SETTLE cycle, so ctr_out is stable.
            if (state_reg == S_SETTLE) begin
                rsp_value_reg   <= ctr_out;
                rsp_count_reg   <= cnt_reg;
                rsp_aborted_reg <= aborted_reg;
            end
        end
    end

`ifdef CNT_SEQ_CHECK_EN
    logic [3:0] expected_value;
    logic       rsp_err_reg;

    cnt_seq_model #(
        .LEN_W (LEN_W)
    ) u_model (
        .cnt_type (ctr_type_reg),
        .cnt_mode (ctr_mode_reg),
        .count    (cnt_reg),
        .expected (expected_value)
    );

    always_ff @(posedge clk) begin
        if (!mstr_reset_n) begin
            rsp_err_reg <= 1'b0;
        end else if (state_reg == S_SETTLE) begin
            rsp_err_reg <= (ctr_out != expected_value);
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    assign ctr_en      = ctr_en_reg;
    assign ctr_reset   = ctr_reset_reg;
    assign ctr_type    = ctr_type_reg;
    assign ctr_mode    = ctr_mode_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_value   = rsp_value_reg;
    assign rsp_count   = rsp_count_reg;
    assign rsp_aborted = rsp_aborted_reg;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Testbench for cnt_seq_ctrl. A behavioural 4-bit binary/BCD up/down counter
// is driven by the sequencer's control pins; responses are checked against a
// scoreboard of expected results pushed when each command is issued.
module tb_cnt_seq_ctrl;

    localparam int LEN_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             mstr_reset_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_type = 1'b0;
    logic             cmd_mode = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_abort = 1'b0;
    logic             rsp_ready = 1'b0;
    logic             cmd_ready, ctr_en, ctr_type, ctr_mode, ctr_reset;
    logic             rsp_valid, rsp_aborted, rsp_err;
    logic [3:0]       ctr_out, rsp_value;
    logic [LEN_W-1:0] rsp_count;

    cnt_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .mstr_reset_n (mstr_reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_mode     (cmd_mode),
        .cmd_len      (cmd_len),
        .cmd_abort    (cmd_abort),
        .ctr_en       (ctr_en),
        .ctr_type     (ctr_type),
        .ctr_mode     (ctr_mode),
        .ctr_reset    (ctr_reset),
        .ctr_out      (ctr_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_value    (rsp_value),
        .rsp_count    (rsp_count),
        .rsp_aborted  (rsp_aborted),
        .rsp_err      (rsp_err)
    );

    // Behavioural counter: updates only on enabled edges; reset loads the
    // direction/type dependent start value.
    logic [3:0] cnt_q = 4'd0;
    logic       force_zero = 1'b0;

    always @(posedge clk) begin
        if (ctr_en) begin
            if (ctr_reset) begin
                cnt_q <= (!ctr_mode) ? 4'd0 : (ctr_type ? 4'd9 : 4'd15);
            end else if (!ctr_mode) begin
                cnt_q <= (ctr_type && cnt_q >= 4'd9) ? 4'd0 : cnt_q + 4'd1;
            end else begin
                cnt_q <= (cnt_q == 4'd0) ? (ctr_type ? 4'd9 : 4'd15) : cnt_q - 4'd1;
            end
        end
    end

    assign ctr_out = force_zero ? 4'd0 : cnt_q;

    typedef struct {
        logic       typ;
        logic       mode;
        logic [7:0] len;
        logic [3:0] value;
    } vec_t;

    typedef struct {
        logic [3:0] value;
        logic [7:0] count;
        logic       aborted;
        logic       err;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[9];
    int   checks   = 0;
    int   failures = 0;

`ifdef CNT_SEQ_CHECK_EN
    localparam logic FORCED_ERR = 1'b1;
`else
    localparam logic FORCED_ERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, optionally abort it in RUN cycle abort_at (1-based),
    // then check the response and hold it for 'hold' cycles before consuming.
    task automatic do_cmd(input logic typ, input logic mode, input logic [7:0] len,
                          input int abort_at, input logic [3:0] exp_value,
                          input logic exp_err, input int hold);
        rsp_t e;
        rsp_t got;
        int   edges;
        int   en_cycles;
        int   rst_cycles;
        int   exp_count;
        exp_count = (abort_at != 0) ? abort_at : int'(len);
        chk("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_type  = typ;
        cmd_mode  = mode;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
        e.value   = exp_value;
        e.count   = 8'(exp_count);
        e.aborted = (abort_at != 0);
        e.err     = exp_err;
        sb_q.push_back(e);
        edges      = 0;
        en_cycles  = 0;
        rst_cycles = 0;
        while (!rsp_valid && edges < 600) begin
            if (ctr_en) en_cycles++;
            if (ctr_reset) rst_cycles++;
            cmd_abort = (abort_at != 0) && (edges == abort_at);
            tick();
            edges++;
        end
        cmd_abort = 1'b0;
        if (!rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout actual=%0d cycles expected=%0d", edges, exp_count + 2);
            void'(sb_q.pop_front());
            return;
        end
        chk("latency", 32'(edges), 32'(exp_count + 2));
        chk("sb_nonempty", 32'(sb_q.size()), 1);
        got = sb_q.pop_front();
        chk("rsp_value", 32'(rsp_value), 32'(got.value));
        chk("rsp_count", 32'(rsp_count), 32'(got.count));
        chk("rsp_aborted", 32'(rsp_aborted), 32'(got.aborted));
        chk("rsp_err", 32'(rsp_err), 32'(got.err));
        chk("en_cycles", 32'(en_cycles), 32'(exp_count + 1));
        chk("reset_cycles", 32'(rst_cycles), 1);
        chk("ctr_type_hold", 32'(ctr_type), 32'(typ));
        chk("ctr_mode_hold", 32'(ctr_mode), 32'(mode));
        chk("cmd_ready_resp", 32'(cmd_ready), 0);
        $display("cmd type=%0d mode=%0d len=%0d abort_at=%0d -> value=%0d count=%0d aborted=%0d err=%0d lat=%0d",
                 typ, mode, len, abort_at, rsp_value, rsp_count, rsp_aborted, rsp_err, edges);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_value", 32'(rsp_value), 32'(got.value));
            chk("stall_count", 32'(rsp_count), 32'(got.count));
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("cmd_ready_back", 32'(cmd_ready), 1);
    endtask

    initial begin
        vecs[0] = '{typ: 1'b0, mode: 1'b0, len: 8'd5,   value: 4'd5};
        vecs[1] = '{typ: 1'b0, mode: 1'b1, len: 8'd20,  value: 4'd11};
        vecs[2] = '{typ: 1'b1, mode: 1'b0, len: 8'd23,  value: 4'd3};
        vecs[3] = '{typ: 1'b1, mode: 1'b1, len: 8'd4,   value: 4'd5};
        vecs[4] = '{typ: 1'b0, mode: 1'b0, len: 8'd16,  value: 4'd0};
        vecs[5] = '{typ: 1'b1, mode: 1'b0, len: 8'd10,  value: 4'd0};
        vecs[6] = '{typ: 1'b0, mode: 1'b1, len: 8'd1,   value: 4'd14};
        vecs[7] = '{typ: 1'b0, mode: 1'b0, len: 8'd255, value: 4'd15};
        vecs[8] = '{typ: 1'b1, mode: 1'b1, len: 8'd255, value: 4'd4};

        // Reset state
        mstr_reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_ctr_en", 32'(ctr_en), 0);
        chk("rst_ctr_reset", 32'(ctr_reset), 0);
        chk("rst_ctr_type", 32'(ctr_type), 0);
        chk("rst_ctr_mode", 32'(ctr_mode), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_value", 32'(rsp_value), 0);
        chk("rst_rsp_count", 32'(rsp_count), 0);
        chk("rst_rsp_aborted", 32'(rsp_aborted), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        mstr_reset_n = 1'b1;
        tick();

        // Table-driven commands
        for (int v = 0; v < 9; v++) begin
            do_cmd(vecs[v].typ, vecs[v].mode, vecs[v].len, 0, vecs[v].value, 1'b0, 0);
        end

        // Abort in the 7th RUN cycle of a long BCD down run
        do_cmd(1'b1, 1'b1, 8'd200, 7, 4'd2, 1'b0, 0);

        // len = 0 with the response held off for 10 cycles
        do_cmd(1'b0, 1'b1, 8'd0, 0, 4'd15, 1'b0, 10);

        // Reset in the middle of a run
        cmd_valid = 1'b1;
        cmd_type  = 1'b1;
        cmd_mode  = 1'b1;
        cmd_len   = 8'd50;
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk("midrun_ctr_en", 32'(ctr_en), 1);
        chk("midrun_cmd_ready", 32'(cmd_ready), 0);
        mstr_reset_n = 1'b0;
        tick();
        mstr_reset_n = 1'b1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_ctr_en", 32'(ctr_en), 0);
        chk("midrst_ctr_reset", 32'(ctr_reset), 0);
        chk("midrst_ctr_type", 32'(ctr_type), 0);
        chk("midrst_ctr_mode", 32'(ctr_mode), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        chk("midrst_idle_hold", 32'(cmd_ready), 1);
        do_cmd(1'b0, 1'b0, 8'd3, 0, 4'd3, 1'b0, 0);

        // Counter output stuck at zero: error flag depends on the check build
        force_zero = 1'b1;
        do_cmd(1'b0, 1'b0, 8'd3, 0, 4'd0, FORCED_ERR, 0);
        force_zero = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
